// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a req/ack imem handshake with a
// one-entry response buffer, and drives the IF/ID pipeline register.
module fetch_stage #(
    parameter int unsigned            ADDR_W   = 32,
    parameter int unsigned            DATA_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic              ifid_en,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc4,
    output logic              if_valid,
    output logic              fetch_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] pc4;
    logic              squash, squash_n;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] buf_data, buf_data_n;
    logic              buf_valid, buf_valid_n;
    logic [DATA_W-1:0] instr_n;
    logic [ADDR_W-1:0] ifpc4_n;
    logic              valid_n;
    logic              advance;
    logic              ack;
    logic              deliver;
    logic [DATA_W-1:0] deliver_instr;

    assign pc4        = pc + ADDR_W'(4);
    assign advance    = pc_en & ifid_en;
    assign ack        = imem_req & imem_ack;
    assign fetch_busy = (state == S_WAIT);

    // Next-state, PC, handshake and IF/ID values; redirect overrides everything else.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        squash_n      = squash;
        req_n         = imem_req;
        addr_n        = imem_addr;
        buf_data_n    = buf_data;
        buf_valid_n   = buf_valid;
        deliver       = 1'b0;
        deliver_instr = buf_data;
        instr_n       = if_instr;
        ifpc4_n       = if_pc4;
        valid_n       = if_valid;

        case (state)
            S_IDLE: begin
                if (!pcsrc) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack) begin
                    req_n    = 1'b0;
                    squash_n = 1'b0;
                    if (pcsrc || squash) begin
                        state_n = S_IDLE;
                    end else if (advance) begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        state_n       = S_IDLE;
                    end else begin
                        buf_data_n  = imem_rdata;
                        buf_valid_n = 1'b1;
                        state_n     = S_HOLD;
                    end
                end else if (pcsrc) begin
                    // Request cannot be withdrawn; its response is dropped on arrival.
                    squash_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (pcsrc) begin
                    state_n = S_IDLE;
                end else if (advance) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_data;
                    buf_valid_n   = 1'b0;
                    state_n       = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (pcsrc) begin
            pc_n        = {branch_target[ADDR_W-1:2], 2'b00};
            buf_valid_n = 1'b0;
        end else if (deliver) begin
            pc_n = pc4;
        end

        if (pcsrc) begin
            instr_n = '0;
            valid_n = 1'b0;
        end else if (deliver) begin
            instr_n = deliver_instr;
            ifpc4_n = pc4;
            valid_n = 1'b1;
        end else if (ifid_en) begin
            instr_n = '0;
            valid_n = 1'b0;
        end
    end

    // State register, PC, handshake outputs, buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            squash    <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
            if_instr  <= '0;
            if_pc4    <= '0;
            if_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            squash    <= squash_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            buf_data  <= buf_data_n;
            buf_valid <= buf_valid_n;
            if_instr  <= instr_n;
            if_pc4    <= ifpc4_n;
            if_valid  <= valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random imem latency, stalls, redirects and stray
// acks, checked against an instruction-stream scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        ifid_en;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        fetch_busy;

    fetch_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (RPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_instr      (if_instr),
        .if_pc4        (if_pc4),
        .if_valid      (if_valid),
        .fetch_busy    (fetch_busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_deliv  = 0;

    // Stimulus knobs and one-shot overrides
    int lat_lo, lat_hi, stall_pct, br_pct, spur_pct;
    logic force_rst, force_br, force_stall, force_ack;
    logic [31:0] force_tgt;

    // Reference model: next instruction address expected in program order
    logic [31:0] exp_pc;
    logic        holding, squash, expect_load;
    logic        req_active;
    int          lat_cnt;

    // Previous-cycle record
    logic        prev_rst, prev_pcsrc, prev_ifid, prev_pcen, prev_ack;
    logic        p_req, p_hold, p_valid;
    logic [31:0] p_addr, p_instr, p_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check();
        if (!prev_rst) begin
            chk("rst_req",   32'(imem_req),   32'd0);
            chk("rst_addr",  imem_addr,       32'd0);
            chk("rst_instr", if_instr,        32'd0);
            chk("rst_pc4",   if_pc4,          32'd0);
            chk("rst_valid", 32'(if_valid),   32'd0);
            chk("rst_busy",  32'(fetch_busy), 32'd0);
            exp_pc     = RPC;
            holding    = 1'b0;
            squash     = 1'b0;
            req_active = 1'b0;
        end else begin
            chk("busy_eq_req", 32'(fetch_busy), 32'(imem_req));
            if (prev_pcsrc) begin
                chk("flush_valid", 32'(if_valid), 32'd0);
                chk("flush_instr", if_instr, 32'd0);
                chk("flush_pc4",   if_pc4,   p_pc4);
            end else if (!prev_ifid) begin
                chk("hold_valid", 32'(if_valid), 32'(p_valid));
                chk("hold_instr", if_instr, p_instr);
                chk("hold_pc4",   if_pc4,   p_pc4);
            end else begin
                chk("load_expected", 32'(if_valid), 32'(expect_load));
                if (if_valid) begin
                    chk("load_pc_en", 32'(prev_pcen), 32'd1);
                    chk("instr", if_instr, mem_word(exp_pc));
                    chk("pc4",   if_pc4,   exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    n_deliv++;
                end else begin
                    chk("bubble_instr", if_instr, 32'd0);
                    chk("bubble_pc4",   if_pc4,   p_pc4);
                end
            end
            if (p_req) begin
                if (prev_ack) begin
                    chk("req_drop_after_ack", 32'(imem_req), 32'd0);
                end else begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_stable", imem_addr, p_addr);
                end
            end else begin
                if (!p_hold && !prev_pcsrc) chk("req_issue", 32'(imem_req), 32'd1);
                if (imem_req) chk("new_req_addr", imem_addr, exp_pc);
            end
        end
        p_hold  = holding;
        p_req   = imem_req;
        p_addr  = imem_addr;
        p_valid = if_valid;
        p_instr = if_instr;
        p_pc4   = if_pc4;
    endtask

    task automatic drive();
        logic        r, pe, ie, br, a, new_hold;
        logic [31:0] tgt, rd;
        r   = !force_rst;
        pe  = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
        ie  = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
        br  = ($urandom_range(0, 99) < br_pct);
        tgt = 32'($urandom_range(0, 511));
        if (force_br) begin
            br  = 1'b1;
            tgt = force_tgt;
        end
        if (force_stall) begin
            pe = 1'b0;
            ie = 1'b0;
        end
        if (!r) br = 1'b0;
        if (imem_req) begin
            if (!req_active) begin
                req_active = 1'b1;
                lat_cnt    = $urandom_range(lat_lo, lat_hi);
            end
            if (lat_cnt == 0) begin
                a          = 1'b1;
                rd         = mem_word(imem_addr);
                req_active = 1'b0;
            end else begin
                a  = 1'b0;
                rd = $urandom;
                lat_cnt--;
            end
        end else begin
            req_active = 1'b0;
            a  = force_ack || ($urandom_range(0, 99) < spur_pct);
            rd = $urandom;
        end
        if (r) begin
            expect_load = !br && pe && ie && ((imem_req && a && !squash) || holding);
            new_hold = holding;
            if (!br && imem_req && a && !squash && !(pe && ie)) new_hold = 1'b1;
            if (br || expect_load) new_hold = 1'b0;
            if (imem_req && a) squash = 1'b0;
            else if (br && imem_req) squash = 1'b1;
            holding = new_hold;
            if (br) exp_pc = tgt & ~32'h3;
        end
        rst           = r;
        pc_en         = pe;
        ifid_en       = ie;
        pcsrc         = br;
        branch_target = tgt;
        imem_ack      = a;
        imem_rdata    = rd;
        prev_rst      = r;
        prev_pcsrc    = br;
        prev_ifid     = ie;
        prev_pcen     = pe;
        prev_ack      = a;
        force_rst     = 1'b0;
        force_br      = 1'b0;
        force_stall   = 1'b0;
        force_ack     = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        check();
        drive();
    endtask

    task automatic knobs(input int llo, input int lhi, input int st, input int br, input int sp);
        lat_lo    = llo;
        lat_hi    = lhi;
        stall_pct = st;
        br_pct    = br;
        spur_pct  = sp;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 12 && !imem_req; i++) step();
        chk(tag, 32'(imem_req), 32'd1);
    endtask

    // Directed phases with randomized detail.
    initial begin
        int d0;
        force_rst = 1'b0; force_br = 1'b0; force_stall = 1'b0; force_ack = 1'b0;
        force_tgt = '0;
        exp_pc = RPC; holding = 1'b0; squash = 1'b0; expect_load = 1'b0;
        req_active = 1'b0; lat_cnt = 0;
        p_req = 1'b0; p_hold = 1'b0; p_valid = 1'b0;
        p_addr = '0; p_instr = '0; p_pc4 = '0;
        rst = 1'b0; pc_en = 1'b0; ifid_en = 1'b0; pcsrc = 1'b0;
        branch_target = '0; imem_ack = 1'b0; imem_rdata = '0;
        prev_rst = 1'b0; prev_pcsrc = 1'b0; prev_ifid = 1'b0; prev_pcen = 1'b0; prev_ack = 1'b0;
        repeat (2) @(posedge clk);

        // Zero-wait memory, no stalls: one instruction every two cycles, PC wraps
        knobs(0, 0, 0, 0, 0);
        repeat (4) step();
        d0 = n_deliv;
        repeat (20) step();
        chk("throughput", 32'(n_deliv - d0), 32'd10);

        // Three-cycle memory latency
        knobs(3, 3, 0, 0, 0);
        repeat (30) step();

        // Heavy stalls with short latency: exercises the response buffer
        knobs(0, 2, 60, 0, 0);
        repeat (60) step();

        // Redirect to 0x103 while a request is outstanding
        knobs(4, 4, 0, 0, 0);
        wait_req("timeout_redirect");
        force_br = 1'b1; force_tgt = 32'h103;
        step();
        knobs(0, 2, 0, 0, 0);
        repeat (20) step();

        // Redirect coinciding with ack; redirect during IF/ID stall
        knobs(1, 1, 0, 0, 0);
        wait_req("timeout_br_ack");
        force_br = 1'b1; force_tgt = 32'h240;
        step();
        repeat (6) step();
        force_br = 1'b1; force_tgt = 32'h80; force_stall = 1'b1;
        step();
        repeat (10) step();

        // Random mix including stray acks
        knobs(0, 3, 30, 10, 20);
        repeat (400) step();

        // Reset in the middle of a request, then a late ack
        knobs(5, 5, 0, 0, 0);
        wait_req("timeout_rst");
        step();
        force_rst = 1'b1;
        step();
        force_ack = 1'b1;
        step();
        knobs(0, 0, 0, 0, 0);
        repeat (20) step();

        @(negedge clk);
        check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
